// File: rtl/lcd_responder.sv
// lcd_responder: device-side model of an HD44780-style character LCD on the
// 8-bit parallel bus. It decodes driver traffic, holds display configuration
// and a 128-byte DDRAM, answers busy-flag/data reads and enforces busy times.
// Optional feature macro: LCD_RESP_SHIFT_EN enables display shifting
// (display_offset); without it display_offset is tied to zero.
module lcd_responder #(
    parameter int CLK_FREQ       = 25,
    parameter int POWERUP_CYCLES = 500 * CLK_FREQ,
    parameter int EXEC_CYCLES    = 37 * CLK_FREQ,
    parameter int CLEAR_CYCLES   = 1530 * CLK_FREQ
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       data_oe,
    output logic       busy_flag,
    output logic [6:0] ddram_addr,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_dec,
    output logic       shift,
    output logic       lines,
    output logic       font,
    output logic [6:0] display_offset,
    output logic       protocol_err
);

    typedef enum logic [1:0] {
        ST_POWERUP = 2'd0,
        ST_IDLE    = 2'd1,
        ST_EXEC    = 2'd2
    } state_t;

    localparam logic [15:0] PWR_LD = 16'(POWERUP_CYCLES);
    localparam logic [15:0] EXE_LD = 16'(EXEC_CYCLES);
    localparam logic [15:0] CLR_LD = 16'(CLEAR_CYCLES);

    // Modulo-128 increment/decrement used for AC and display offset.
    function automatic logic [6:0] step7(input logic [6:0] v, input logic up);
        logic [6:0] r;
        if (up) begin
            r = v + 7'd1;
        end else begin
            r = v - 7'd1;
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    logic        e_q, rs_q, rw_q;
    logic [7:0]  din_q;

    logic [6:0]  ac_q, ac_d;
    logic [6:0]  off_q, off_d;
    logic        disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic        id_q, id_d, sh_q, sh_d, lines_q, lines_d, font_q, font_d;

    logic [7:0]  ddram_q [0:127];

    logic [7:0]  dout_q;
    logic        oe_q;
    logic        perr_q;

    logic        fall_s, idle_s, bf_read_s, accept_s, reject_s;
    logic        clear_s, wr_s, long_s;
    logic [7:0]  rd_val_s;

    // Bus event qualification: a falling edge of e acts on the captured access.
    always_comb begin
        fall_s    = e_q & ~e;
        idle_s    = (state_q == ST_IDLE);
        bf_read_s = ~rs_q & rw_q;
        accept_s  = fall_s & idle_s & ~bf_read_s;
        reject_s  = fall_s & ~idle_s & ~bf_read_s;
    end

    // Read data presented at data_oe rise: busy flag/AC, DDRAM, or 0 when busy.
    always_comb begin
        rd_val_s = 8'h00;
        if (!rs) begin
            rd_val_s = {~idle_s, ac_q};
        end else if (idle_s) begin
            rd_val_s = ddram_q[ac_q];
        end else begin
            rd_val_s = 8'h00;
        end
    end

    // Access decode: next AC, offset and configuration for an accepted access.
    always_comb begin
        ac_d    = ac_q;
        off_d   = off_q;
        disp_d  = disp_q;
        cur_d   = cur_q;
        blink_d = blink_q;
        id_d    = id_q;
        sh_d    = sh_q;
        lines_d = lines_q;
        font_d  = font_q;
        clear_s = 1'b0;
        wr_s    = 1'b0;
        long_s  = 1'b0;
        if (accept_s) begin
            if (rs_q) begin
                ac_d = step7(ac_q, id_q);
                if (!rw_q) begin
                    wr_s = 1'b1;
`ifdef LCD_RESP_SHIFT_EN
                    if (sh_q) begin
                        off_d = step7(off_q, id_q);
                    end else begin
                        off_d = off_q;
                    end
`endif
                end else begin
                    wr_s = 1'b0;
                end
            end else begin
                // Instruction decoded by its highest set bit.
                casez (din_q)
                    8'b1???_????: ac_d = din_q[6:0];
                    8'b01??_????: ac_d = ac_q;
                    8'b001?_????: begin
                        lines_d = din_q[3];
                        font_d  = din_q[2];
                    end
                    8'b0001_????: begin
                        if (!din_q[3]) begin
                            ac_d = step7(ac_q, din_q[2]);
                        end else begin
`ifdef LCD_RESP_SHIFT_EN
                            off_d = step7(off_q, din_q[2]);
`else
                            off_d = off_q;
`endif
                        end
                    end
                    8'b0000_1???: begin
                        disp_d  = din_q[2];
                        cur_d   = din_q[1];
                        blink_d = din_q[0];
                    end
                    8'b0000_01??: begin
                        id_d = din_q[1];
                        sh_d = din_q[0];
                    end
                    8'b0000_001?: begin
                        ac_d   = 7'd0;
                        off_d  = 7'd0;
                        long_s = 1'b1;
                    end
                    8'b0000_0001: begin
                        clear_s = 1'b1;
                        ac_d    = 7'd0;
                        off_d   = 7'd0;
                        id_d    = 1'b1;
                        long_s  = 1'b1;
                    end
                    default: ac_d = ac_q;
                endcase
            end
        end else begin
            wr_s = 1'b0;
        end
    end

    // Busy FSM next state: power-up wait, idle, and post-access busy time.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_POWERUP, ST_EXEC: begin
                if (cnt_q <= 16'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_EXEC;
                    cnt_d   = long_s ? CLR_LD : EXE_LD;
                end else begin
                    cnt_d = 16'd0;
                end
            end
            default: begin
                state_d = ST_POWERUP;
                cnt_d   = PWR_LD;
            end
        endcase
    end

    // Busy FSM state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_POWERUP;
            cnt_q   <= PWR_LD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Address counter, display offset and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac_q    <= 7'd0;
            off_q   <= 7'd0;
            disp_q  <= 1'b0;
            cur_q   <= 1'b0;
            blink_q <= 1'b0;
            id_q    <= 1'b1;
            sh_q    <= 1'b0;
            lines_q <= 1'b0;
            font_q  <= 1'b0;
        end else begin
            ac_q    <= ac_d;
            off_q   <= off_d;
            disp_q  <= disp_d;
            cur_q   <= cur_d;
            blink_q <= blink_d;
            id_q    <= id_d;
            sh_q    <= sh_d;
            lines_q <= lines_d;
            font_q  <= font_d;
        end
    end

    // DDRAM: not reset; clear fills every cell with a space in one cycle.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            for (int i = 0; i < 128; i++) begin
                ddram_q[i] <= 8'h20;
            end
        end else if (wr_s) begin
            ddram_q[ac_q] <= din_q;
        end
    end

    // Bus front end: e history, access capture, read drive and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q    <= 1'b0;
            rs_q   <= 1'b0;
            rw_q   <= 1'b0;
            din_q  <= 8'h00;
            oe_q   <= 1'b0;
            dout_q <= 8'h00;
            perr_q <= 1'b0;
        end else begin
            e_q <= e;
            if (e) begin
                rs_q  <= rs;
                rw_q  <= rw;
                din_q <= lcd_data_in;
            end
            oe_q <= e & rw;
            if (e && rw && !oe_q) begin
                dout_q <= rd_val_s;
            end
            perr_q <= reject_s;
        end
    end

    assign lcd_data_out   = dout_q;
    assign data_oe        = oe_q;
    assign busy_flag      = (state_q != ST_IDLE);
    assign ddram_addr     = ac_q;
    assign display_on     = disp_q;
    assign cursor_on      = cur_q;
    assign blink_on       = blink_q;
    assign inc_dec        = id_q;
    assign shift          = sh_q;
    assign lines          = lines_q;
    assign font           = font_q;
    assign display_offset = off_q;
    assign protocol_err   = perr_q;

endmodule
